// File: rtl/ad9361_sample_packer.sv
// ad9361_sample_packer: pairs AD9361 dual-channel strobes into 64-bit words behind a FWFT FIFO.
// Define AD9361_PACKER_OVF_COUNT_EN to get a saturating dropped-word counter on ovf_count.
module ad9361_sample_packer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int MSB_ALIGN   = 0,
    parameter int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   valid_0,
    input  logic [11:0]            data_i0,
    input  logic [11:0]            data_q0,
    input  logic                   valid_1,
    input  logic [11:0]            data_i1,
    input  logic [11:0]            data_q1,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_data,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   overflow,
    output logic                   misalign,
    output logic [15:0]            ovf_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, HAVE0} state_t;
    state_t state, state_nxt;
    logic [11:0] held_i, held_q;
    logic load0, pack, use_held, mis_set;
    logic pk_valid;
    logic [63:0] pk_data;
    logic [63:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, pop, full;

    function automatic logic [15:0] widen(input logic [11:0] x);
        return MSB_ALIGN != 0 ? {x, 4'b0} : {{4{x[11]}}, x};
    endfunction

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    always_comb begin
        state_nxt = state;
        load0 = 1'b0;
        pack = 1'b0;
        use_held = 1'b0;
        mis_set = 1'b0;
        if (!en)
            state_nxt = IDLE;
        else if (state == IDLE) begin
            if (valid_0 && valid_1)
                pack = 1'b1;
            else if (valid_0) begin
                load0 = 1'b1;
                state_nxt = HAVE0;
            end else if (valid_1)
                mis_set = 1'b1;
        end else begin
            if (valid_0 && valid_1) begin
                pack = 1'b1;
                mis_set = 1'b1;
                state_nxt = IDLE;
            end else if (valid_1) begin
                pack = 1'b1;
                use_held = 1'b1;
                state_nxt = IDLE;
            end else if (valid_0) begin
                load0 = 1'b1;
                mis_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load0) begin
            held_i <= data_i0;
            held_q <= data_q0;
        end
        pk_data <= {widen(data_q1), widen(data_i1),
                    widen(use_held ? held_q : data_q0), widen(use_held ? held_i : data_i0)};
    end

    always_ff @(posedge clk)
        if (rst) begin
            pk_valid <= 1'b0;
            misalign <= 1'b0;
        end else begin
            pk_valid <= pack;
            misalign <= misalign | mis_set;
        end

    // A full FIFO still accepts a word when the head is popped in the same cycle.
    assign full      = level == LEVEL_WIDTH'(FIFO_DEPTH);
    assign out_valid = level != '0;
    assign pop       = out_valid & out_ready;
    assign push      = pk_valid & (~full | pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= pk_data;

    always_ff @(posedge clk)
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(pop);
            if (pk_valid && !push) overflow <= 1'b1;
        end

`ifdef AD9361_PACKER_OVF_COUNT_EN
    always_ff @(posedge clk)
        if (rst)
            ovf_count <= '0;
        else if (pk_valid && !push && ovf_count != 16'hFFFF)
            ovf_count <= ovf_count + 16'd1;
`else
    assign ovf_count = 16'h0;
`endif
endmodule

// File: tb/tb_ad9361_sample_packer.sv
// tb_ad9361_sample_packer: scoreboard bench; sign-extend and left-justify instances share stimulus.
module tb_ad9361_sample_packer;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, out_ready = 1'b0;
    logic valid_0 = 1'b0, valid_1 = 1'b0;
    logic [11:0] data_i0 = '0, data_q0 = '0, data_i1 = '0, data_q1 = '0;
    logic out_valid, overflow, misalign, lj_valid, lj_overflow, lj_misalign;
    logic [63:0] out_data, lj_data;
    logic [4:0] level, lj_level;
    logic [15:0] ovf_count, lj_ovf_count;
    int checks = 0, errors = 0;
    logic [127:0] sb[$];

    ad9361_sample_packer #(.FIFO_DEPTH(16), .MSB_ALIGN(0)) u_sx (
        .clk(clk), .rst(rst), .en(en), .valid_0(valid_0), .data_i0(data_i0), .data_q0(data_q0),
        .valid_1(valid_1), .data_i1(data_i1), .data_q1(data_q1), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .level(level), .overflow(overflow),
        .misalign(misalign), .ovf_count(ovf_count));

    ad9361_sample_packer #(.FIFO_DEPTH(16), .MSB_ALIGN(1)) u_lj (
        .clk(clk), .rst(rst), .en(en), .valid_0(valid_0), .data_i0(data_i0), .data_q0(data_q0),
        .valid_1(valid_1), .data_i1(data_i1), .data_q1(data_q1), .out_valid(lj_valid),
        .out_ready(out_ready), .out_data(lj_data), .level(lj_level), .overflow(lj_overflow),
        .misalign(lj_misalign), .ovf_count(lj_ovf_count));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] expect_word(input logic [11:0] i0, q0, i1, q1);
        return {q1, 4'h0, i1, 4'h0, q0, 4'h0, i0, 4'h0,
                {4{q1[11]}}, q1, {4{i1[11]}}, i1, {4{q0[11]}}, q0, {4{i0[11]}}, i0};
    endfunction

    always @(negedge clk)
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0)
                chk("unexpected_word", 64'd1, 64'd0);
            else begin
                logic [127:0] e;
                e = sb.pop_front();
                chk("data_sx", out_data, e[63:0]);
                chk("data_lj", lj_data, e[127:64]);
            end
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, v1, input logic [11:0] i0, q0, i1, q1);
        valid_0 = v0; valid_1 = v1;
        data_i0 = i0; data_q0 = q0; data_i1 = i1; data_q1 = q1;
        step();
    endtask

    task automatic idle(input int n);
        valid_0 = 1'b0; valid_1 = 1'b0;
        repeat (n) step();
    endtask

    task automatic set_both(input bit keep);
        logic [11:0] a, b, c, d;
        a = 12'($urandom); b = 12'($urandom); c = 12'($urandom); d = 12'($urandom);
        valid_0 = 1'b1; valid_1 = 1'b1;
        data_i0 = a; data_q0 = b; data_i1 = c; data_q1 = d;
        if (keep) sb.push_back(expect_word(a, b, c, d));
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) step();
        chk("drain_done", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) step();
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_level", level, 0);
        chk("rst_flags", {overflow, misalign}, 0);
        chk("rst_ovfcnt", ovf_count, 0);
        rst = 1'b0; en = 1'b1; out_ready = 1'b1;
        step();

        // pairing and latency
        sb.push_back(expect_word(12'h801, 12'h7FF, 12'h001, 12'hFFF));
        drive(1, 0, 12'h801, 12'h7FF, 12'h000, 12'h000);
        drive(0, 1, 12'h000, 12'h000, 12'h001, 12'hFFF);
        idle(0);
        @(negedge clk);
        chk("lat_c2_valid", out_valid, 0);
        step();
        @(negedge clk);
        chk("lat_c3_valid", out_valid, 1);
        chk("tp_sx", out_data, 64'hFFFF_0001_07FF_F801);
        chk("tp_lj", lj_data, 64'hFFF0_0010_7FF0_8010);
        step();
        @(negedge clk);
        chk("lat_level", level, 0);
        chk("lat_flags", {overflow, misalign}, 0);

        // en dropped while holding ch0
        drive(1, 0, 12'h123, 12'h456, 12'h000, 12'h000);
        en = 1'b0;
        idle(1);
        en = 1'b1;
        idle(4);
        @(negedge clk);
        chk("en_drop_valid", out_valid, 0);
        chk("en_drop_mis", misalign, 0);

        // valid_1 alone from IDLE (also shows the en drop returned to IDLE)
        drive(0, 1, 12'h000, 12'h000, 12'h3A5, 12'h5A3);
        idle(1);
        @(negedge clk);
        chk("mis_v1_flag", misalign, 1);
        idle(3);
        @(negedge clk);
        chk("mis_v1_noword", out_valid, 0);

        // double valid_0 then valid_1: second ch0 wins
        drive(1, 0, 12'h111, 12'h222, 12'h000, 12'h000);
        drive(1, 0, 12'hABC, 12'hDEF, 12'h000, 12'h000);
        sb.push_back(expect_word(12'hABC, 12'hDEF, 12'h876, 12'h0F0));
        drive(0, 1, 12'h000, 12'h000, 12'h876, 12'h0F0);
        idle(1);
        drain();
        idle(4);
        @(negedge clk);
        chk("mis_one_word", out_valid, 0);

        // overflow: 18 pairs into a 16-deep FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            set_both(i < 16);
            step();
        end
        idle(3);
        @(negedge clk);
        chk("ovf_level", level, 16);
        chk("ovf_flag", overflow, 1);
`ifdef AD9361_PACKER_OVF_COUNT_EN
        chk("ovf_count", ovf_count, 2);
`else
        chk("ovf_count", ovf_count, 0);
`endif
        out_ready = 1'b1;
        drain();
        idle(1);
        @(negedge clk);
        chk("ovf_drained", level, 0);
        chk("ovf_sticky", {overflow, misalign}, 2'b11);

        // reset mid-burst with words queued and ch0 held
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_both(1'b0);
            step();
        end
        drive(1, 0, 12'h777, 12'h666, 12'h000, 12'h000);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rstm_valid", out_valid, 0);
        chk("rstm_level", level, 0);
        chk("rstm_flags", {overflow, misalign}, 0);
        chk("rstm_ovfcnt", ovf_count, 0);
        out_ready = 1'b1;
        idle(4);
        @(negedge clk);
        chk("rstm_nopartial", out_valid, 0);

        // full with simultaneous pop
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_both(1'b1);
            step();
        end
        idle(3);
        @(negedge clk);
        chk("fp_full", level, 16);
        set_both(1'b1);
        step();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_both(1'b1);
            @(negedge clk);
            chk("fp_level_hold", level, 16);
            step();
        end
        idle(1);
        @(negedge clk);
        chk("fp_no_ovf", overflow, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/ad9361_sample_packer.md
Name: ad9361_sample_packer

Overview:
Downstream stage of the AD9361 CMOS RX interface; clocked by the same clock that captures the dual-port samples.
- Pairs the per-channel strobes (valid_0 with I0/Q0, valid_1 with I1/Q1) into one coherent two-channel sample.
- Widens each 12-bit component to 16 bits.
- Buffers packed 64-bit words in a FIFO and presents them on a valid/ready stream to the DMA/processing path.
- Flags channel misalignment and FIFO overflow.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of 2, >= 4.
- MSB_ALIGN, 0, 0 = sign-extend 12->16 (replicate bit 11); 1 = left-justify ({x,4'b0}).
- LEVEL_WIDTH, log2(FIFO_DEPTH)+1, derived; width of fill level.

Ports:
- clk  input  1  core clock; same clock as the upstream capture registers.
- rst  input  1  synchronous, active-high reset.
- en  input  1  capture enable; low = ignore input strobes.
- valid_0  input  1  channel 0 sample strobe.
- data_i0  input  12  channel 0 I.
- data_q0  input  12  channel 0 Q.
- valid_1  input  1  channel 1 sample strobe.
- data_i1  input  12  channel 1 I.
- data_q1  input  12  channel 1 Q.
- out_valid  output  1  FIFO head word valid.
- out_ready  input  1  consumer accepts head word.
- out_data  output  64  {q1,i1,q0,i0}, 16 bits each; i0 in [15:0].
- level  output  LEVEL_WIDTH  FIFO occupancy, 0..FIFO_DEPTH.
- overflow  output  1  sticky: packed word dropped while FIFO full.
- misalign  output  1  sticky: pairing error detected.
- ovf_count  output  16  dropped-word count (optional feature).

Behaviour:
- Reset (synchronous, active-high): state IDLE; FIFO empty; out_valid=0; out_data=0; level=0; overflow=0; misalign=0; ovf_count=0.
- Pairing FSM, states IDLE and HAVE0:
  - IDLE, valid_0 only: latch I0/Q0 -> HAVE0.
  - IDLE, valid_1 only: discard, set misalign, stay IDLE.
  - IDLE, valid_0 & valid_1 same cycle: pack current ch0+ch1, stay IDLE.
  - HAVE0, valid_1 only: pack held ch0 + current ch1 -> IDLE.
  - HAVE0, valid_0 only: replace held ch0, set misalign, stay HAVE0.
  - HAVE0, both: pack current ch0+ch1, drop held ch0, set misalign -> IDLE.
  - HAVE0, neither: hold.
  - en=0: strobes ignored, FSM forced to IDLE next cycle, held ch0 discarded silently. FIFO keeps draining.
- Pack stage is registered: pairing completes in cycle N; widened word registered at N+1; written to FIFO on the N+1 edge; out_valid high in cycle N+2 if FIFO was empty. Fixed latency 2 cycles, strobe to out_valid.
- Width rule: each component widened independently per MSB_ALIGN. Component order fixed as in out_data.
- FIFO behaviour:
  - First-word-fall-through: out_data is valid whenever out_valid=1.
  - Pop when out_valid & out_ready.
  - out_data holds stable while out_valid=1 and out_ready=0.
  - Push only when a packed word is present.
  - Full means level==FIFO_DEPTH. Push while full with no pop: word dropped, overflow set, ovf_count++.
  - Push while full with a same-cycle pop: accepted, level unchanged, no overflow.
  - Push+pop when empty: level stays 0 for that cycle; the word appears at the head per normal latency.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - level updates the cycle after each push/pop.
- overflow and misalign clear only on rst.
- Reset asserted mid-stream: FIFO contents and any held ch0 are lost; no partial word is emitted after rst deasserts.

Optional Feature:
- Macro AD9361_PACKER_OVF_COUNT_EN.
- Defined: ovf_count is a 16-bit counter of dropped words; saturates at 16'hFFFF and does not wrap; cleared on rst.
- Undefined: no counter logic; ovf_count tied to 16'h0. The overflow flag behaves identically in both cases.

Test Plan:
- Pairing and latency: en=1, valid_0 (i0=12'h801, q0=12'h7FF) in cycle 0, valid_1 (i1=12'h001, q1=12'hFFF) in cycle 1, MSB_ALIGN=0, out_ready=1 -> out_valid in cycle 3, out_data=64'hFFFF_0001_07FF_F801, level returns to 0, flags 0.
- Left-justify: same stimulus with MSB_ALIGN=1 -> out_data=64'hFFF0_0010_7FF0_8010.
- Misalignment:
  - valid_1 alone from IDLE -> no word, misalign=1.
  - Then valid_0 twice followed by valid_1 -> exactly one word, containing the second ch0.
- Overflow: out_ready=0, FIFO_DEPTH=16, 18 complete pairs -> level=16, overflow=1, ovf_count=2 with macro defined (0 without). Then out_ready=1 -> the first 16 words drain in order.
- Full with simultaneous pop: FIFO full, out_ready=1 with a pair completing every cycle -> level holds at 16, no overflow, words in order.
- Control: en dropped while in HAVE0 -> no word emitted, misalign unchanged. rst mid-burst -> out_valid=0, level=0 the next cycle, flags cleared.
